// File: rtl/filter_scan_ctrl_pkg.sv
// Shared settings for the filter scan sequencer: sizes, default timing and FSM state type.
package filter_scan_ctrl_pkg;

  localparam int SIZE_DELAY       = 8;
  localparam int SIZE_FILTER_DATA = 16;
  localparam int N_FILTERS        = 21;
  localparam int SETTLE_LEN_DEF   = 64;
  localparam int WINDOW_LEN_DEF   = 256;

  typedef enum logic [2:0] {
    SCAN_IDLE,
    SCAN_SETTLE,
    SCAN_ACQ,
    SCAN_REPORT,
    SCAN_FINISH
  } scan_state_t;

  // True when the step at cur is the last one of the sweep (the carry bit catches wrap-around).
  function automatic logic sweep_is_last(input logic [SIZE_DELAY-1:0] cur,
                                         input logic [SIZE_DELAY-1:0] last,
                                         input logic [SIZE_DELAY-1:0] step);
    logic [SIZE_DELAY:0] nxt;
    nxt = {1'b0, cur} + {1'b0, step};
    return (step == '0) || (cur == last) || nxt[SIZE_DELAY] ||
           (nxt[SIZE_DELAY-1:0] > last);
  endfunction

endpackage

// File: rtl/filter_scan_ctrl_peak.sv
// Window peak tracker: signed running maximum, first index of that maximum, optional window sum.
// Sum accumulator is built only when FILTER_SCAN_SUM_EN is defined.
module filter_peak_tracker #(
  parameter int DATA_W = 16,
  parameter int POS_W  = 8,
  parameter int SUM_W  = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [DATA_W-1:0] peak,
  output logic        [POS_W-1:0]  pos,
  output logic        [SUM_W-1:0]  sum
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] r_peak;
  logic        [POS_W-1:0]  r_pos;
  logic        [POS_W-1:0]  r_idx;

  // Strict greater-than keeps the earliest index on ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_peak <= '0;
      r_pos  <= '0;
      r_idx  <= '0;
    end else if (clear) begin
      r_peak <= MOST_NEG;
      r_pos  <= '0;
      r_idx  <= '0;
    end else if (enable) begin
      r_idx <= r_idx + 1'b1;
      if (sample > r_peak) begin
        r_peak <= sample;
        r_pos  <= r_idx;
      end
    end
  end

  assign peak = r_peak;
  assign pos  = r_pos;

`ifdef FILTER_SCAN_SUM_EN
  logic [SUM_W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_sum <= '0;
    end else if (enable) begin
      r_sum <= r_sum + {{(SUM_W-DATA_W){sample[DATA_W-1]}}, sample};
    end
  end

  assign sum = r_sum;
`else
  assign sum = '0;
`endif

endmodule

// File: rtl/filter_scan_ctrl.sv
// Delay-sweep sequencer: drives the generator controls, measures one filter per step and
// reports peak/position (and the window sum when FILTER_SCAN_SUM_EN is defined).
module filter_scan_ctrl
  import filter_scan_ctrl_pkg::*;
#(
  parameter int SETTLE_LEN = SETTLE_LEN_DEF,
  parameter int WINDOW_LEN = WINDOW_LEN_DEF,
  localparam int POS_W     = $clog2(WINDOW_LEN),
  localparam int SUM_W     = SIZE_FILTER_DATA + POS_W
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [4:0]                            filter_sel,
  input  logic                                  cfg_overlay,
  input  logic                                  cfg_rate,
  input  logic [SIZE_DELAY-1:0]                 delay_first,
  input  logic [SIZE_DELAY-1:0]                 delay_last,
  input  logic [SIZE_DELAY-1:0]                 delay_step,
  input  logic [N_FILTERS*SIZE_FILTER_DATA-1:0] filter_data,
  output logic                                  test_overlay,
  output logic                                  test_rate,
  output logic [SIZE_DELAY-1:0]                 test_delay,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  sel_err,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic [SIZE_DELAY-1:0]                 result_delay,
  output logic [SIZE_FILTER_DATA-1:0]           result_peak,
  output logic [POS_W-1:0]                      result_pos,
  output logic [SUM_W-1:0]                      result_sum
);

  localparam int CNT_MAX = (SETTLE_LEN > WINDOW_LEN) ? SETTLE_LEN : WINDOW_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_LEN - 1);
  localparam logic [4:0]       N_FILT_SEL  = 5'(N_FILTERS);

  scan_state_t                  r_state;
  logic [CNT_W-1:0]             r_cnt;
  logic [4:0]                   r_sel;
  logic                         r_overlay;
  logic                         r_rate;
  logic [SIZE_DELAY-1:0]        r_delay;
  logic [SIZE_DELAY-1:0]        r_last;
  logic [SIZE_DELAY-1:0]        r_step;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_sel_err;
  logic                         r_result_valid;
  logic signed [SIZE_FILTER_DATA-1:0] r_sample;

  logic                               w_trk_clear;
  logic                               w_trk_en;
  logic signed [SIZE_FILTER_DATA-1:0] w_peak;
  logic [POS_W-1:0]                   w_pos;
  logic [SUM_W-1:0]                   w_sum;

  // Registered filter mux: one cycle of latency between the bus and the tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample <= '0;
    end else begin
      r_sample <= filter_data[int'(r_sel)*SIZE_FILTER_DATA +: SIZE_FILTER_DATA];
    end
  end

  // Scan FSM with step counter, sweep arithmetic and result handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= SCAN_IDLE;
      r_cnt          <= '0;
      r_sel          <= '0;
      r_overlay      <= 1'b0;
      r_rate         <= 1'b0;
      r_delay        <= '0;
      r_last         <= '0;
      r_step         <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_sel_err      <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_sel_err <= 1'b0;
      case (r_state)
        SCAN_IDLE: begin
          if (start) begin
            if (filter_sel < N_FILT_SEL) begin
              r_sel     <= filter_sel;
              r_overlay <= cfg_overlay;
              r_rate    <= cfg_rate;
              r_delay   <= delay_first;
              r_last    <= delay_last;
              r_step    <= delay_step;
              r_busy    <= 1'b1;
              r_cnt     <= '0;
              r_state   <= SCAN_SETTLE;
            end else begin
              r_sel_err <= 1'b1;
            end
          end
        end
        SCAN_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            r_cnt   <= '0;
            r_state <= SCAN_ACQ;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SCAN_ACQ: begin
          if (r_cnt == WINDOW_LAST) begin
            r_cnt          <= '0;
            r_result_valid <= 1'b1;
            r_state        <= SCAN_REPORT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SCAN_REPORT: begin
          if (result_ready) begin
            r_result_valid <= 1'b0;
            if (sweep_is_last(r_delay, r_last, r_step)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= SCAN_FINISH;
            end else begin
              r_delay <= r_delay + r_step;
              r_state <= SCAN_SETTLE;
            end
          end
        end
        SCAN_FINISH: begin
          r_overlay <= 1'b0;
          r_rate    <= 1'b0;
          r_delay   <= '0;
          r_state   <= SCAN_IDLE;
        end
        default: begin
          r_busy         <= 1'b0;
          r_result_valid <= 1'b0;
          r_overlay      <= 1'b0;
          r_rate         <= 1'b0;
          r_delay        <= '0;
          r_state        <= SCAN_IDLE;
        end
      endcase
    end
  end

  assign w_trk_clear = (r_state == SCAN_SETTLE);
  assign w_trk_en    = (r_state == SCAN_ACQ);

  filter_peak_tracker #(
    .DATA_W (SIZE_FILTER_DATA),
    .POS_W  (POS_W),
    .SUM_W  (SUM_W)
  ) u_tracker (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_trk_clear),
    .enable (w_trk_en),
    .sample (r_sample),
    .peak   (w_peak),
    .pos    (w_pos),
    .sum    (w_sum)
  );

  assign test_overlay = r_overlay;
  assign test_rate    = r_rate;
  assign test_delay   = r_delay;
  assign busy         = r_busy;
  assign done         = r_done;
  assign sel_err      = r_sel_err;
  assign result_valid = r_result_valid;
  assign result_delay = r_delay;
  assign result_peak  = w_peak;
  assign result_pos   = w_pos;
  assign result_sum   = w_sum;

endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Directed self-checking bench for filter_scan_ctrl (SETTLE_LEN=4, WINDOW_LEN=8).
module tb_filter_scan_ctrl;
  import filter_scan_ctrl_pkg::*;

  localparam int W = SIZE_FILTER_DATA;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic [4:0]              filter_sel;
  logic                    cfg_overlay;
  logic                    cfg_rate;
  logic [SIZE_DELAY-1:0]   delay_first;
  logic [SIZE_DELAY-1:0]   delay_last;
  logic [SIZE_DELAY-1:0]   delay_step;
  logic [N_FILTERS*W-1:0]  filter_data;
  logic                    test_overlay;
  logic                    test_rate;
  logic [SIZE_DELAY-1:0]   test_delay;
  logic                    busy;
  logic                    done;
  logic                    sel_err;
  logic                    result_valid;
  logic                    result_ready;
  logic [SIZE_DELAY-1:0]   result_delay;
  logic [W-1:0]            result_peak;
  logic [2:0]              result_pos;
  logic [W+2:0]            result_sum;

  int checks   = 0;
  int failures = 0;

  filter_scan_ctrl #(.SETTLE_LEN(4), .WINDOW_LEN(8)) dut (
    .clk(clk), .reset(reset), .start(start), .filter_sel(filter_sel),
    .cfg_overlay(cfg_overlay), .cfg_rate(cfg_rate),
    .delay_first(delay_first), .delay_last(delay_last), .delay_step(delay_step),
    .filter_data(filter_data),
    .test_overlay(test_overlay), .test_rate(test_rate), .test_delay(test_delay),
    .busy(busy), .done(done), .sel_err(sel_err),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_delay(result_delay), .result_peak(result_peak),
    .result_pos(result_pos), .result_sum(result_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full sweep with ready held high; records reported delays and the done cycle.
  task automatic run_sweep(input logic [7:0] f, input logic [7:0] l, input logic [7:0] s,
                           output int nres, output int done_n,
                           output logic [7:0] d0, output logic [7:0] d1, output logic [7:0] d2);
    filter_sel = 5'd0; delay_first = f; delay_last = l; delay_step = s;
    result_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nres = 0; done_n = -1; d0 = 8'd0; d1 = 8'd0; d2 = 8'd0;
    for (int n = 0; n < 400 && done_n < 0; n++) begin
      if (done) begin
        done_n = n;
        chk("done_busy_low", {31'd0, busy}, 32'd0);
      end else if (result_valid) begin
        if (nres == 0) d0 = result_delay;
        else if (nres == 1) d1 = result_delay;
        else d2 = result_delay;
        nres++;
      end
      @(negedge clk);
    end
  endtask

  int          nres, done_n, n, pulses;
  logic [7:0]  d0, d1, d2;
  logic [15:0] samp [8];
  logic [31:0] snap;
  logic [31:0] exp_sum;

  initial begin
    samp[0] = 16'hFFFD; samp[1] = 16'd7; samp[2] = 16'd2; samp[3] = 16'd7;
    samp[4] = 16'hFFFF; samp[5] = 16'd0; samp[6] = 16'd0; samp[7] = 16'd0;
`ifdef FILTER_SCAN_SUM_EN
    exp_sum = 32'd12;
`else
    exp_sum = 32'd0;
`endif
    reset = 1'b1; start = 1'b0; filter_sel = 5'd0; cfg_overlay = 1'b0; cfg_rate = 1'b0;
    delay_first = 8'd0; delay_last = 8'd0; delay_step = 8'd0; result_ready = 1'b0;
    filter_data = '0;
    filter_data[4*W +: W] = 16'd100;
    filter_data[6*W +: W] = 16'd90;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_ctrl",  {22'd0, test_overlay, test_rate, test_delay}, 32'd0);
    chk("rst_res",   {13'd0, result_peak, result_pos}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Rejected start
    filter_sel = 5'd21; cfg_overlay = 1'b1; delay_first = 8'd33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rej_sel_err", {31'd0, sel_err}, 32'd1);
    chk("rej_busy",    {31'd0, busy}, 32'd0);
    chk("rej_ctrl",    {22'd0, test_overlay, test_rate, test_delay}, 32'd0);
    @(negedge clk);
    chk("rej_pulse_end", {31'd0, sel_err}, 32'd0);
    chk("rej_ctrl2",     {23'd0, busy, test_delay}, 32'd0);

    // Peak/tie on filter 5 with backpressure, two steps 7..8
    filter_sel = 5'd5; cfg_overlay = 1'b1; cfg_rate = 1'b0;
    delay_first = 8'd7; delay_last = 8'd8; delay_step = 8'd1; result_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("acc_busy",  {31'd0, busy}, 32'd1);
    chk("acc_ctrl",  {22'd0, test_overlay, test_rate, test_delay}, {22'd0, 2'b10, 8'd7});
    filter_sel = 5'd4; delay_first = 8'd99; cfg_overlay = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      filter_data[5*W +: W] = samp[i];
      @(negedge clk);
    end
    @(negedge clk);
    chk("tie_valid", {31'd0, result_valid}, 32'd1);
    chk("tie_peak",  {16'd0, result_peak}, 32'd7);
    chk("tie_pos",   {29'd0, result_pos}, 32'd1);
    chk("tie_sum",   {13'd0, result_sum}, exp_sum);
    chk("tie_delay", {24'd0, result_delay}, 32'd7);
    snap = {4'd0, result_valid, result_peak, result_pos, test_delay};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_stable", {4'd0, result_valid, result_peak, result_pos, test_delay}, snap);
    end
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_xfer_valid", {31'd0, result_valid}, 32'd0);
    chk("bp_next_delay", {23'd0, busy, test_delay}, {23'd0, 1'b1, 8'd8});
    n = 1;
    while (!result_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_gap", n, 32'd13);
    chk("s2_delay", {24'd0, result_delay}, 32'd8);
    chk("s2_peak_latched_sel", {13'd0, result_peak, result_pos}, 32'd0);
    @(negedge clk);
    chk("s2_done", {30'd0, done, busy}, 32'd2);
    @(negedge clk);
    chk("s2_idle", {21'd0, done, test_overlay, test_rate, test_delay}, 32'd0);

    // Sweep 10..30 step 10
    run_sweep(8'd10, 8'd30, 8'd10, nres, done_n, d0, d1, d2);
    chk("sw_count", nres, 32'd3);
    chk("sw_delays", {8'd0, d0, d1, d2}, {8'd0, 8'd10, 8'd20, 8'd30});
    chk("sw_done_cycle", done_n, 32'd39);

    // Overflow stop 250..255 step 4
    run_sweep(8'd250, 8'd255, 8'd4, nres, done_n, d0, d1, d2);
    chk("ov_count", nres, 32'd2);
    chk("ov_delays", {16'd0, d0, d1}, {16'd0, 8'd250, 8'd254});
    chk("ov_done_cycle", done_n, 32'd26);

    // Zero step and reversed bounds: one step each
    run_sweep(8'd5, 8'd50, 8'd0, nres, done_n, d0, d1, d2);
    chk("z_step", {nres[15:0], 8'd0, d0}, {16'd1, 8'd0, 8'd5});
    run_sweep(8'd40, 8'd10, 8'd3, nres, done_n, d0, d1, d2);
    chk("rev_bounds", {nres[15:0], 8'd0, d0}, {16'd1, 8'd0, 8'd40});

    // Reset mid-scan during ACQ
    filter_sel = 5'd4; cfg_overlay = 1'b1; cfg_rate = 1'b1;
    delay_first = 8'd3; delay_last = 8'd9; delay_step = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_ctrl", {20'd0, busy, result_valid, test_overlay, test_rate, test_delay}, 32'd0);
    chk("mrst_res",  {13'd0, result_peak, result_pos}, 32'd0);
    chk("mrst_sum",  {13'd0, result_sum}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (done || busy) pulses++;
      @(negedge clk);
    end
    chk("mrst_no_done", pulses, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mrst_restart", {23'd0, busy, test_delay}, {23'd0, 1'b1, 8'd3});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/filter_scan_ctrl.md
# filter_scan_ctrl

Sequencer for the filter test bench. It drives the `exp_sig_gen` controls (`test_overlay`, `test_rate`, `test_delay`) through a delay sweep. At each step it measures one selected `vN_filter` output over a fixed acquisition window and reports the peak value and peak position per step through a valid/ready result port. It sits beside the filter top level: its generator outputs feed the generator's `overlay`/`rate`/`delay` inputs, and the filter outputs arrive on a flattened bus.

## Interface
- `SIZE_DELAY`, package value: width of the generator delay.
- `SIZE_FILTER_DATA`, package value: width of one filter output, signed.
- `N_FILTERS`, 21: number of filter outputs on the bus.
- `SETTLE_LEN`, 64: cycles between applying a delay and starting acquisition. Must be ≥1.
- `WINDOW_LEN`, 256: acquisition window in cycles. Must be ≥2.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: scan request, accepted only in IDLE.
- `filter_sel` in 5: index of the measured filter, 0..N_FILTERS-1.
- `cfg_overlay`, `cfg_rate` in 1: generator mode bits, latched at start.
- `delay_first`, `delay_last`, `delay_step` in SIZE_DELAY: sweep bounds and step, latched at start.
- `filter_data` in N_FILTERS*SIZE_FILTER_DATA: filter k occupies bits [k*W +: W].
- `test_overlay`, `test_rate` out 1: generator mode bits.
- `test_delay` out SIZE_DELAY: generator delay.
- `busy` out 1: high from start acceptance until done.
- `done` out 1: one-cycle pulse at scan end.
- `sel_err` out 1: one-cycle pulse when a start is rejected.
- `result_valid` out 1 / `result_ready` in 1: result handshake.
- `result_delay` out SIZE_DELAY: delay of the reported step.
- `result_peak` out SIZE_FILTER_DATA: maximum signed sample in the window.
- `result_pos` out clog2(WINDOW_LEN): window index of the first occurrence of the peak.
- `result_sum` out SIZE_FILTER_DATA+clog2(WINDOW_LEN): window sum, see Configuration.

## Operation
- States: IDLE → SETTLE → ACQ → REPORT → (SETTLE | FINISH) → IDLE.
- **IDLE**
  - On `start` with `filter_sel < N_FILTERS`: latch all cfg inputs, load `test_delay = delay_first`, go to SETTLE.
  - On `start` with `filter_sel ≥ N_FILTERS`: pulse `sel_err`, stay in IDLE.
- **SETTLE**
  - Counts `SETTLE_LEN` cycles with the generator controls stable.
  - The peak tracker is cleared: peak = most-negative value, pos = 0, sum = 0.
- **ACQ**
  - Counts `WINDOW_LEN` cycles and samples the selected filter each cycle through a registered mux.
  - The tracker updates on strict greater-than only, so ties keep the earlier index.
- **REPORT**
  - `result_*` are registered and `result_valid` goes high.
  - All result outputs stay stable until a cycle where `result_valid && result_ready`. The generator controls are unchanged during this wait.
  - On transfer:
    - If `delay == delay_last`, or `delay + delay_step` overflows SIZE_DELAY, or `delay + delay_step > delay_last`: go to FINISH.
    - Otherwise add `delay_step` to `test_delay` and go to SETTLE.
- **Sweep corner cases**
  - `delay_step = 0` or `delay_last < delay_first`: exactly one step, at `delay_first`.
- **FINISH**: pulse `done`, drop `busy`, go to IDLE.
- **Start outside IDLE**: ignored. Cfg input changes outside IDLE are ignored.
- **Generator controls in IDLE**: `test_overlay = test_rate = 0`, `test_delay = 0`. In all other states they carry the latched values.
- **Arithmetic**
  - Peak compare is signed.
  - The sum is sign-extended and cannot overflow by construction.
  - The delay increment uses SIZE_DELAY+1 bits to detect overflow.

## Timing
- **Reset values**
  - State IDLE.
  - `busy`, `done`, `sel_err`, `result_valid` = 0.
  - All data outputs and generator controls = 0.
- **Reset mid-scan**: returns to IDLE on the next edge and discards any pending result. No `done` pulse is issued.
- **First sample**: `start` sampled at edge t. `busy` and `test_delay` are valid from t+1. ACQ begins at t+1+SETTLE_LEN.
- **Sample alignment**: the mux register adds 1 cycle. The sample taken at ACQ cycle i gets index i, for the filter value present one cycle earlier.
- **Result timing**: `result_valid` rises in the cycle after the last ACQ cycle.
- **Step-to-step gap**: the next SETTLE starts the cycle after transfer. With `result_ready` held high, each step takes SETTLE_LEN+WINDOW_LEN+1 cycles.
- **End of scan**: `done` pulses the cycle after the final transfer, and `busy` is low in that same cycle.

## Configuration
- `FILTER_SCAN_SUM_EN`
  - Defined: the tracker accumulates the window sum, and `result_sum` carries it.
  - Undefined: no accumulator is built and `result_sum` is tied to 0.
  - All other behaviour is identical in both builds.

## Structure
- `package_settings` gains:
  - `N_FILTERS`.
  - The default `SETTLE_LEN` / `WINDOW_LEN`.
  - `typedef enum logic [2:0] {SCAN_IDLE, SCAN_SETTLE, SCAN_ACQ, SCAN_REPORT, SCAN_FINISH} scan_state_t`.
- One sub-module, `filter_peak_tracker`:
  - Inputs: clear, enable, sample.
  - Outputs: peak, pos, sum.
  - The FSM, counters and handshake stay in `filter_scan_ctrl`.

## Test plan
- **Sweep**: SETTLE_LEN=4, WINDOW_LEN=8, sweep 10..30 step 10, ready held high. Expect 3 results with delays 10, 20, 30, then `done` exactly 3×13 cycles after busy rises.
- **Peak and tie**: filter 5 driven with window samples {-3,7,2,7,-1,0,0,0}. Expect peak=7, pos=1, and sum=12 with SUM_EN.
- **Backpressure**: `result_ready` low for 20 cycles in REPORT. Expect `result_*` and `test_delay` stable throughout, and the next SETTLE starting the cycle after the ready transfer.
- **Rejected start**: `filter_sel`=21. Expect a single `sel_err` pulse, `busy` staying 0, and controls staying 0.
- **Overflow stop**: SIZE_DELAY=8, sweep 250..255 step 4. Expect results for delays 250 and 254 only, then `done`.
- **Reset mid-scan**: `reset` asserted during ACQ. Expect all outputs zero on the next edge, no `done`, and a new `start` accepted normally.
